// File: rtl/vec_pkg.sv
// Shared definitions for the vector result collector: width helpers,
// collector FSM states and result-bus field positions.
package vec_pkg;

  // Ceiling log2 of n, evaluated at elaboration time.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed to index n items (never less than one bit).
  function automatic int bitwidth(input int n);
    return (n <= 2) ? 1 : log2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } collect_state_e;

  // Result bus layout: {valid, mask, data}.
  function automatic int res_valid_bit(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int res_mask_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/vec_collect_watchdog.sv
// Idle-cycle watchdog for the result collector; only instantiated when
// VEC_COLLECTOR_TIMEOUT_EN is defined.
import vec_pkg::*;

module vec_collect_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = bitwidth(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (!enable || clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Fires on the idle cycle whose edge would bring the count to the limit.
  assign expired = enable && !clear && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/vec_result_collector.sv
// Collects a VLR-element FU result stream and writes mask-enabled elements
// to the VRF. Optional idle watchdog under VEC_COLLECTOR_TIMEOUT_EN.
import vec_pkg::*;

module vec_result_collector #(
  parameter int DATA_WIDTH     = 32,
  parameter int MVL            = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [bitwidth(MVL):0]        VLR,
  input  logic [DATA_WIDTH+1:0]         res_in,
  output logic                          wr_en,
  output logic [bitwidth(MVL)-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          busy,
  output logic                          done,
  output logic [bitwidth(MVL):0]        wr_count,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int AW = bitwidth(MVL);
  localparam int CW = AW + 1;
  localparam int RES_VALID_BIT = res_valid_bit(DATA_WIDTH);
  localparam int RES_MASK_BIT  = res_mask_bit(DATA_WIDTH);

  collect_state_e state_reg, state_next;

  logic [AW-1:0]         idx_reg;
  logic [CW-1:0]         vlr_reg;
  logic [CW-1:0]         wr_count_reg;
  logic                  wr_en_reg;
  logic [AW-1:0]         wr_addr_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic                  overrun_reg;
  logic                  timeout_reg;

  logic res_valid, res_mask;
  logic collecting, accept, last_elem, start_ok, timeout_hit;

  assign res_valid  = res_in[RES_VALID_BIT];
  assign res_mask   = res_in[RES_MASK_BIT];
  assign collecting = (state_reg == COLLECT);
  assign accept     = collecting && res_valid;
  assign last_elem  = ({1'b0, idx_reg} == (vlr_reg - CW'(1)));
  assign start_ok   = (state_reg == IDLE) && start;

`ifdef VEC_COLLECTOR_TIMEOUT_EN
  vec_collect_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .enable  (collecting),
    .clear   (res_valid),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (VLR == '0) ? DONE : COLLECT;
      COLLECT: if ((accept && last_elem) || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      COLLECT: busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg      <= '0;
      vlr_reg      <= '0;
      wr_count_reg <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      overrun_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      if (start_ok) begin
        vlr_reg      <= VLR;
        idx_reg      <= '0;
        wr_count_reg <= '0;
        overrun_reg  <= 1'b0;
        timeout_reg  <= 1'b0;
      end
      // Masked-off elements still consume an index but leave the VRF untouched.
      if (accept) begin
        idx_reg <= idx_reg + AW'(1);
        if (res_mask) begin
          wr_en_reg    <= 1'b1;
          wr_addr_reg  <= idx_reg;
          wr_data_reg  <= res_in[DATA_WIDTH-1:0];
          wr_count_reg <= wr_count_reg + CW'(1);
        end
      end
      if (!collecting && res_valid) overrun_reg <= 1'b1;
      if (timeout_hit)              timeout_reg <= 1'b1;
    end
  end

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign wr_count = wr_count_reg;
  assign overrun  = overrun_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_vec_result_collector.sv
// Scoreboard bench for vec_result_collector; the watchdog scenario runs only
// when VEC_COLLECTOR_TIMEOUT_EN is defined.
module tb_vec_result_collector;

  localparam int DW  = 32;
  localparam int MVL = 32;
  localparam int AW  = 5;
  localparam int CW  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] VLR = '0;
  logic [DW+1:0] res_in = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done;
  logic [CW-1:0] wr_count;
  logic          overrun, timeout;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int wr_total = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;

  vec_result_collector #(
    .DATA_WIDTH     (DW),
    .MVL            (MVL),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .VLR      (VLR),
    .res_in   (res_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Write monitor: every VRF write must match the oldest expected write.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      wr_total++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h required no write", wr_addr, wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        $display("write addr=%0d data=%h", wr_addr, wr_data);
        if ({wr_addr, wr_data} !== exp_w) begin
          errors++;
          $display("FAIL write_match got addr=%0d data=%h required addr=%0d data=%h",
                   wr_addr, wr_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input int n);
    start = 1'b1;
    VLR   = CW'(n);
    tick();
    start = 1'b0;
    VLR   = '0;
  endtask

  task automatic send(input bit m, input logic [DW-1:0] d, input int addr);
    res_in = {1'b1, m, d};
    if (m) exp_q.push_back({AW'(addr), d});
    tick();
    res_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({wr_en, busy, done, overrun, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 00000", {wr_en, busy, done, overrun, timeout});
    end
    checks++;
    if ({wr_addr, wr_data, wr_count} !== '0) begin
      errors++;
      $display("FAIL reset_values got addr=%0d data=%h count=%0d required 0", wr_addr, wr_data, wr_count);
    end
    rst = 1'b1;
    tick();
    $display("reset done");
  endtask

  task automatic test_basic();
    logic [DW-1:0] d[4];
    d = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    done_cnt = 0;
    start_vec(4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b required 1", busy);
    end
    for (int i = 0; i < 4; i++) send(1'b1, d[i], i);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b required done=1 busy=0", done, busy);
    end
    checks++;
    if (wr_count !== CW'(4)) begin
      errors++;
      $display("FAIL basic_count got %0d required 4", wr_count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || done_cnt != 1 || exp_q.size() != 0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_end got done=%b pulses=%0d pending=%0d timeout=%b required 0 1 0 0",
               done, done_cnt, exp_q.size(), timeout);
    end
    $display("basic collection finished");
  endtask

  task automatic test_masked();
    bit m[5];
    m = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    done_cnt = 0;
    start_vec(5);
    for (int i = 0; i < 5; i++) begin
      send(m[i], 32'hA000_0000 + 32'(i), i);
      if (i < 4) begin
        tick();
        tick();
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL masked_done got %b required 1", done);
    end
    tick();
    checks++;
    if (wr_count !== CW'(3) || done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL masked_end got count=%0d pulses=%0d pending=%0d required 3 1 0",
               wr_count, done_cnt, exp_q.size());
    end
    $display("masked collection finished");
  endtask

  task automatic test_vlr0();
    int w0;
    bit busy_seen;
    w0 = wr_total;
    done_cnt = 0;
    busy_seen = 1'b0;
    start_vec(0);
    busy_seen |= busy;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL vlr0_done got %b required 1", done);
    end
    tick();
    busy_seen |= busy;
    tick();
    checks++;
    if (done !== 1'b0 || busy_seen || wr_count !== '0 || done_cnt != 1 || wr_total != w0) begin
      errors++;
      $display("FAIL vlr0_end got done=%b busy_seen=%b count=%0d pulses=%0d writes=%0d required 0 0 0 1 0",
               done, busy_seen, wr_count, done_cnt, wr_total - w0);
    end
    $display("vlr0 finished");
  endtask

  task automatic test_stray();
    res_in = {1'b1, 1'b1, 32'hDEAD_BEEF};
    tick();
    res_in = '0;
    checks++;
    if (overrun !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL stray_overrun got overrun=%b wr_en=%b required 1 0", overrun, wr_en);
    end
    tick();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL stray_sticky got %b required 1", overrun);
    end
    start_vec(1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL stray_clear got %b required 0", overrun);
    end
    send(1'b1, 32'h1234_5678, 0);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stray_done got %b required 1", done);
    end
    tick();
    $display("stray element finished");
  endtask

  task automatic test_start_busy();
    int w0;
    w0 = wr_total;
    start_vec(3);
    send(1'b1, 32'h0000_0011, 0);
    start = 1'b1;
    VLR   = CW'(5);
    send(1'b1, 32'h0000_0022, 1);
    start = 1'b0;
    VLR   = '0;
    send(1'b1, 32'h0000_0033, 2);
    checks++;
    if (done !== 1'b1 || wr_count !== CW'(3)) begin
      errors++;
      $display("FAIL busy_start_done got done=%b count=%0d required 1 3", done, wr_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0 || wr_total - w0 != 3) begin
      errors++;
      $display("FAIL busy_start_end got busy=%b pending=%0d writes=%0d required 0 0 3",
               busy, exp_q.size(), wr_total - w0);
    end
    $display("start while busy finished");
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_total;
    start_vec(3);
    send(1'b1, 32'h0000_00AA, 0);
    tick();
    res_in = {1'b1, 1'b1, 32'h0000_00BB};
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({wr_en, busy, done} !== 3'b000 || wr_count !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_mid got wr_en=%b busy=%b done=%b count=%0d addr=%0d data=%h required all 0",
               wr_en, busy, done, wr_count, wr_addr, wr_data);
    end
    res_in = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0 || wr_total - w0 != 1) begin
      errors++;
      $display("FAIL reset_mid_end got busy=%b pending=%0d writes=%0d required 0 0 1",
               busy, exp_q.size(), wr_total - w0);
    end
    $display("reset mid-collection finished");
  endtask

`ifdef VEC_COLLECTOR_TIMEOUT_EN
  task automatic test_watchdog();
    int k;
    start_vec(4);
    send(1'b1, 32'h0000_0101, 0);
    send(1'b1, 32'h0000_0202, 1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL watchdog_delay got %0d cycles required 8", k);
    end
    checks++;
    if (timeout !== 1'b1 || wr_count !== CW'(2)) begin
      errors++;
      $display("FAIL watchdog_flags got timeout=%b count=%0d required 1 2", timeout, wr_count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_sticky got done=%b timeout=%b required 0 1", done, timeout);
    end
    start_vec(1);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_clear got %b required 0", timeout);
    end
    send(1'b1, 32'h0000_0303, 0);
    tick();
    $display("watchdog finished");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_masked();
    test_vlr0();
    test_stray();
    test_start_busy();
    test_reset_mid();
`ifdef VEC_COLLECTOR_TIMEOUT_EN
    test_watchdog();
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
